// File: rtl/snn_delay_layer_if.sv
// Host-side bundle for snn_delay_layer: step/spike strobes, config write port, status and debug.
interface snn_delay_layer_if #(
  parameter int N_IN   = 4,
  parameter int N_OUT  = 2,
  parameter int ADDR_W = 4,
  parameter int VBITS  = 8,
  parameter int SELW   = (N_OUT > 1) ? $clog2(N_OUT) : 1
);
  logic              step;
  logic [N_IN-1:0]   in_spikes;
  logic              cfg_we;
  logic [ADDR_W-1:0] cfg_addr;
  logic [7:0]        cfg_wdata;
  logic [SELW-1:0]   debug_sel;
  logic [N_OUT-1:0]  out_spikes;
  logic              out_valid;
  logic              busy;
  logic              overrun;
  logic              cfg_err;
  logic [VBITS-1:0]  debug_v;

  modport master (
    output step, in_spikes, cfg_we, cfg_addr, cfg_wdata, debug_sel,
    input  out_spikes, out_valid, busy, overrun, cfg_err, debug_v
  );

  modport slave (
    input  step, in_spikes, cfg_we, cfg_addr, cfg_wdata, debug_sel,
    output out_spikes, out_valid, busy, overrun, cfg_err, debug_v
  );
endinterface

// File: rtl/snn_delay_layer.sv
// Fully-connected LIF layer with per-synapse signed weights and axonal delays, one input column per cycle.
// Optional macro SNN_REFRACTORY_EN: a neuron that fired sits out the following step.

module snn_lif_neuron #(
  parameter int WBITS = 4,
  parameter int VBITS = 8
) (
  input  logic             system_clock,
  input  logic             reset,
  input  logic             leak_i,
  input  logic             acc_i,
  input  logic             fire_i,
  input  logic [2:0]       leak_shift_i,
  input  logic             hit_i,
  input  logic [WBITS-1:0] w_i,
  input  logic [VBITS-2:0] thresh_i,
  output logic [VBITS-1:0] v_o,
  output logic             spike_o
);
  logic signed [VBITS-1:0] v_q, v_d;
  logic signed [VBITS-1:0] wext, leak_amt;
  logic signed [VBITS:0]   sum;
  logic                    blocked, over_th, spike;

`ifdef SNN_REFRACTORY_EN
  logic refr_q, refr_d;
  assign blocked = refr_q;
  assign refr_d  = fire_i ? spike : refr_q;
  always_ff @(posedge system_clock) begin
    if (reset) refr_q <= 1'b0;
    else       refr_q <= refr_d;
  end
`else
  assign blocked = 1'b0;
`endif

  always_comb begin
    wext     = VBITS'($signed(w_i));
    sum      = {v_q[VBITS-1], v_q} + {wext[VBITS-1], wext};
    leak_amt = v_q >>> leak_shift_i;
    over_th  = (v_q >= $signed({1'b0, thresh_i}));
    spike    = fire_i & over_th & ~blocked;
    v_d      = v_q;
    if (leak_i && !blocked && leak_shift_i != 3'd0) begin
      v_d = v_q - leak_amt;
    end else if (acc_i && hit_i && !blocked) begin
      // overflow shows up as disagreement between the two top bits
      if (sum[VBITS] != sum[VBITS-1])
        v_d = sum[VBITS] ? {1'b1, {(VBITS-1){1'b0}}} : {1'b0, {(VBITS-1){1'b1}}};
      else
        v_d = sum[VBITS-1:0];
    end else if (spike) begin
      v_d = '0;
    end
  end

  always_ff @(posedge system_clock) begin
    if (reset) v_q <= '0;
    else       v_q <= v_d;
  end

  assign v_o     = v_q;
  assign spike_o = spike;
endmodule

module snn_delay_layer #(
  parameter int N_IN        = 4,
  parameter int N_OUT       = 2,
  parameter int WBITS       = 4,
  parameter int DBITS       = 2,
  parameter int VBITS       = 8,
  parameter int THRESH_INIT = 16,
  parameter int ADDR_W      = 4
) (
  input  logic system_clock,
  input  logic reset,
  snn_delay_layer_if.slave bus
);
  localparam int N_S  = N_IN * N_OUT;
  localparam int HD   = 1 << DBITS;
  localparam int IW   = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int SELW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ACCUM, S_FIRE} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            busy, leak_en, acc_en, fire_en, cfg_ok;

  logic [N_IN-1:0]                        cap_q, cap_d;
  logic [N_IN-1:0][HD-1:0]                hist_q, hist_d;
  logic [N_IN-1:0][N_OUT-1:0][WBITS-1:0]  w_q, w_d;
  logic [N_IN-1:0][N_OUT-1:0][DBITS-1:0]  d_q, d_d;
  logic [VBITS-2:0]                       thr_q, thr_d;
  logic [2:0]                             leak_q, leak_d;
  logic [N_OUT-1:0]                       spk_q, spk_d;
  logic                                   vld_q, vld_d;
  logic                                   ovr_q, ovr_d;
  logic                                   cerr_q, cerr_d;

  logic [N_OUT-1:0]                       hit, spike_n;
  logic [N_OUT-1:0][WBITS-1:0]            wcol;
  logic [N_OUT-1:0][VBITS-1:0]            v_all;
  logic [VBITS-1:0]                       dbg;
  logic                                   unused_wdata;

  assign unused_wdata = ^bus.cfg_wdata;

  always_ff @(posedge system_clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE:  if (bus.step) state_d = S_LOAD;
      S_LOAD:  begin state_d = S_ACCUM; idx_d = '0; end
      S_ACCUM: begin
        if (idx_q == IW'(N_IN - 1)) state_d = S_FIRE;
        else                        idx_d   = idx_q + 1'b1;
      end
      S_FIRE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != S_IDLE);
    leak_en = (state_q == S_LOAD);
    acc_en  = (state_q == S_ACCUM);
    fire_en = (state_q == S_FIRE);
  end

  assign cfg_ok = bus.cfg_we & ~busy;

  always_comb begin
    cap_d  = cap_q;
    hist_d = hist_q;
    w_d    = w_q;
    d_d    = d_q;
    thr_d  = thr_q;
    leak_d = leak_q;
    spk_d  = spk_q;
    ovr_d  = ovr_q | (busy & bus.step);
    cerr_d = cerr_q | (busy & bus.cfg_we);
    vld_d  = fire_en;
    if (!busy && bus.step) cap_d = bus.in_spikes;
    // slot 0 always holds the spike of the step being processed
    if (leak_en)
      for (int i = 0; i < N_IN; i++) hist_d[i] = HD'({hist_q[i], cap_q[i]});
    if (cfg_ok) begin
      for (int i = 0; i < N_IN; i++)
        for (int j = 0; j < N_OUT; j++)
          if (bus.cfg_addr == ADDR_W'(i * N_OUT + j)) begin
            w_d[i][j] = bus.cfg_wdata[WBITS-1:0];
            d_d[i][j] = bus.cfg_wdata[WBITS+DBITS-1:WBITS];
          end
      if (bus.cfg_addr == ADDR_W'(N_S))     thr_d  = bus.cfg_wdata[VBITS-2:0];
      if (bus.cfg_addr == ADDR_W'(N_S + 1)) leak_d = bus.cfg_wdata[2:0];
    end
    if (fire_en) spk_d = spike_n;
  end

  always_ff @(posedge system_clock) begin
    if (reset) begin
      cap_q  <= '0;
      hist_q <= '0;
      w_q    <= '0;
      d_q    <= '0;
      thr_q  <= (VBITS-1)'(THRESH_INIT);
      leak_q <= '0;
      spk_q  <= '0;
      vld_q  <= 1'b0;
      ovr_q  <= 1'b0;
      cerr_q <= 1'b0;
    end else begin
      cap_q  <= cap_d;
      hist_q <= hist_d;
      w_q    <= w_d;
      d_q    <= d_d;
      thr_q  <= thr_d;
      leak_q <= leak_d;
      spk_q  <= spk_d;
      vld_q  <= vld_d;
      ovr_q  <= ovr_d;
      cerr_q <= cerr_d;
    end
  end

  always_comb begin
    for (int j = 0; j < N_OUT; j++) begin
      wcol[j] = w_q[idx_q][j];
      hit[j]  = hist_q[idx_q][d_q[idx_q][j]];
    end
  end

  for (genvar j = 0; j < N_OUT; j++) begin : g_nrn
    snn_lif_neuron #(.WBITS(WBITS), .VBITS(VBITS)) u_nrn (
      .system_clock (system_clock),
      .reset        (reset),
      .leak_i       (leak_en),
      .acc_i        (acc_en),
      .fire_i       (fire_en),
      .leak_shift_i (leak_q),
      .hit_i        (hit[j]),
      .w_i          (wcol[j]),
      .thresh_i     (thr_q),
      .v_o          (v_all[j]),
      .spike_o      (spike_n[j])
    );
  end

  always_comb begin
    dbg = '0;
    for (int j = 0; j < N_OUT; j++)
      if (bus.debug_sel == SELW'(j)) dbg = v_all[j];
  end

  assign bus.out_spikes = spk_q;
  assign bus.out_valid  = vld_q;
  assign bus.busy       = busy;
  assign bus.overrun    = ovr_q;
  assign bus.cfg_err    = cerr_q;
  assign bus.debug_v    = dbg;
endmodule

// File: tb/tb_snn_delay_layer.sv
// Randomised bench for snn_delay_layer against a step-level integer model of the layer.
module tb_snn_delay_layer;
  localparam int N_IN = 4, N_OUT = 2, WBITS = 4, DBITS = 2, VBITS = 8, ADDR_W = 4;
  localparam int N_S = N_IN * N_OUT, HD = 1 << DBITS;
`ifdef SNN_REFRACTORY_EN
  localparam bit REFR = 1'b1;
`else
  localparam bit REFR = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  snn_delay_layer_if #(.N_IN(N_IN), .N_OUT(N_OUT), .ADDR_W(ADDR_W), .VBITS(VBITS)) bus ();

  snn_delay_layer #(.N_IN(N_IN), .N_OUT(N_OUT), .WBITS(WBITS), .DBITS(DBITS), .VBITS(VBITS),
                    .THRESH_INIT(16), .ADDR_W(ADDR_W))
    dut (.system_clock(clk), .reset(rst), .bus(bus));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // step-level model
  int mw[N_IN][N_OUT], md[N_IN][N_OUT], mthr, mlk, mv[N_OUT];
  bit mhist[N_IN][HD];
  bit mrefr[N_OUT];
  bit [N_OUT-1:0] mspk;
  bit movr, mcerr;

  function automatic int sat(input int x);
    int lo = -(1 << (VBITS - 1)), hi = (1 << (VBITS - 1)) - 1;
    return (x > hi) ? hi : (x < lo) ? lo : x;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_IN; i++) begin
      for (int j = 0; j < N_OUT; j++) begin mw[i][j] = 0; md[i][j] = 0; end
      for (int k = 0; k < HD; k++) mhist[i][k] = 0;
    end
    for (int j = 0; j < N_OUT; j++) begin mv[j] = 0; mrefr[j] = 0; end
    mthr = 16; mlk = 0; mspk = '0; movr = 0; mcerr = 0;
  endtask

  task automatic model_cfg(input int addr, input logic [7:0] data);
    if (addr < N_S) begin
      mw[addr / N_OUT][addr % N_OUT] = (data[3:0] >= 8) ? int'(data[3:0]) - 16 : int'(data[3:0]);
      md[addr / N_OUT][addr % N_OUT] = int'(data[5:4]);
    end else if (addr == N_S) mthr = int'(data[6:0]);
    else if (addr == N_S + 1) mlk = int'(data[2:0]);
  endtask

  task automatic model_step(input logic [N_IN-1:0] in);
    bit blk;
    for (int i = 0; i < N_IN; i++) begin
      for (int k = HD - 1; k > 0; k--) mhist[i][k] = mhist[i][k-1];
      mhist[i][0] = in[i];
    end
    for (int j = 0; j < N_OUT; j++) begin
      blk = REFR && mrefr[j];
      if (!blk && mlk != 0) mv[j] = mv[j] - (mv[j] >>> mlk);
      for (int i = 0; i < N_IN; i++)
        if (!blk && mhist[i][md[i][j]]) mv[j] = sat(mv[j] + mw[i][j]);
      mspk[j] = !blk && (mv[j] >= mthr);
      if (mspk[j]) mv[j] = 0;
      mrefr[j] = mspk[j];
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic cfg_write(input int addr, input logic [7:0] data);
    @(negedge clk);
    bus.cfg_we = 1'b1; bus.cfg_addr = ADDR_W'(addr); bus.cfg_wdata = data;
    @(negedge clk);
    bus.cfg_we = 1'b0;
    model_cfg(addr, data);
  endtask

  task automatic check_v(input string tag);
    for (int j = 0; j < N_OUT; j++) begin
      bus.debug_sel = 1'(j);
      #1;
      chk(tag, $signed(bus.debug_v), mv[j]);
    end
  endtask

  // inj: 0 none, 1 step in cycle 3, 2 cfg write in cycle 3
  task automatic run_step(input logic [N_IN-1:0] in, input int inj);
    int k;
    @(negedge clk);
    bus.step = 1'b1; bus.in_spikes = in;
    model_step(in);
    @(negedge clk);
    bus.step = 1'b0; bus.in_spikes = N_IN'($urandom);
    k = 1;
    chk("busy_c1", bus.busy, 1);
    while (!bus.out_valid && k < 20) begin
      if (k == 3 && inj == 1) begin
        bus.step = 1'b1; bus.in_spikes = N_IN'($urandom); movr = 1;
      end
      if (k == 3 && inj == 2) begin
        bus.cfg_we = 1'b1; bus.cfg_addr = '0; bus.cfg_wdata = 8'($urandom); mcerr = 1;
      end
      @(negedge clk);
      bus.step = 1'b0; bus.cfg_we = 1'b0;
      k++;
    end
    chk("latency", k, N_IN + 3);
    chk("spikes", bus.out_spikes, mspk);
    chk("busy_done", bus.busy, 0);
    check_v("membrane");
    chk("overrun", bus.overrun, movr);
    chk("cfg_err", bus.cfg_err, mcerr);
    @(negedge clk);
    chk("valid_pulse", bus.out_valid, 0);
    chk("spikes_hold", bus.out_spikes, mspk);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pulses;
    bit [4:0] pat;
    bus.step = 0; bus.in_spikes = '0; bus.cfg_we = 0; bus.cfg_addr = '0;
    bus.cfg_wdata = '0; bus.debug_sel = '0;

    // reset state
    do_reset();
    chk("rst_spikes", bus.out_spikes, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_overrun", bus.overrun, 0);
    chk("rst_cfg_err", bus.cfg_err, 0);
    check_v("rst_v");

    // integrate and fire
    cfg_write(0, 8'h07);
    cfg_write(N_S, 8'd10);
    run_step(4'b0001, 0);
    chk("if_s1_spk", bus.out_spikes, 0);
    bus.debug_sel = 1'b0; #1; chk("if_s1_v0", $signed(bus.debug_v), 7);
    run_step(4'b0001, 0);
    chk("if_s2_spk", bus.out_spikes, 2'b01);
    bus.debug_sel = 1'b0; #1; chk("if_s2_v0", $signed(bus.debug_v), 0);

    // axonal delay of two steps
    do_reset();
    cfg_write(1 * N_OUT + 1, 8'h27);
    cfg_write(N_S, 8'd5);
    run_step(4'b0010, 0);
    chk("dly_k0", bus.out_spikes[1], 0);
    run_step(4'b0000, 0);
    chk("dly_k1", bus.out_spikes[1], 0);
    run_step(4'b0000, 0);
    chk("dly_k2", bus.out_spikes[1], 1);
    run_step(4'b0000, 0);
    chk("dly_k3", bus.out_spikes[1], 0);

    // negative saturation, then leak back toward zero
    do_reset();
    cfg_write(0, 8'h08);
    for (int s = 0; s < 20; s++) run_step(4'b0001, 0);
    bus.debug_sel = 1'b0; #1; chk("sat_v0", $signed(bus.debug_v), -128);
    cfg_write(N_S + 1, 8'd1);
    run_step(4'b0000, 0);
    bus.debug_sel = 1'b0; #1; chk("leak1_v0", $signed(bus.debug_v), -64);
    run_step(4'b0000, 0);
    bus.debug_sel = 1'b0; #1; chk("leak2_v0", $signed(bus.debug_v), -32);
    for (int s = 0; s < 4; s++) run_step(4'b0000, 0);

    // busy violations: dropped step and dropped config write
    do_reset();
    cfg_write(0, 8'h15);
    cfg_write(N_S, 8'd5);
    run_step(4'b0000, 1);
    run_step(4'b0001, 2);
    run_step(4'b0000, 0);
    run_step(4'b0001, 0);
    run_step(4'b0000, 0);

    // reset in the middle of a step abandons it
    do_reset();
    cfg_write(0, 8'h07);
    @(negedge clk);
    bus.step = 1'b1; bus.in_spikes = 4'b0001;
    @(negedge clk);
    bus.step = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.out_valid) pulses++;
    end
    chk("midrst_valid", pulses, 0);
    chk("midrst_busy", bus.busy, 0);
    check_v("midrst_v");

    // refractory behaviour
    do_reset();
    cfg_write(0, 8'h07);
    cfg_write(N_S, 8'd5);
    pat = REFR ? 5'b10101 : 5'b11111;
    for (int s = 0; s < 5; s++) begin
      run_step(4'b0001, 0);
      chk("refr_pat", bus.out_spikes[0], pat[s]);
    end

    // randomised configuration and traffic
    do_reset();
    for (int a = 0; a < N_S; a++) cfg_write(a, 8'($urandom_range(0, 63)));
    cfg_write(N_S, 8'($urandom_range(0, 30)));
    cfg_write(N_S + 1, 8'($urandom_range(0, 3)));
    cfg_write(N_S + 3, 8'($urandom));
    for (int s = 0; s < 40; s++) begin
      int r;
      if (s % 8 == 7) cfg_write($urandom_range(0, N_S + 1), 8'($urandom_range(0, 63)));
      r = $urandom_range(0, 9);
      run_step(N_IN'($urandom), (r == 0) ? 1 : (r == 1) ? 2 : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
